// File: rtl/uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// uart_rx_deserializer
//
// Oversampling UART receiver. The serial line is synchronized, a falling edge
// starts a frame, and each bit is decided by a 2-of-3 majority of samples taken
// around the bit centre. Good bytes appear on RX_OUT_P with a one-cycle
// RX_OUT_V strobe. Parity and framing problems are reported as one-cycle
// pulses, and errored frames never touch RX_OUT_P.
//
// Ports
//   RST            in   async reset, active-low
//   RX_CLK         in   oversampling clock, Prescale cycles per bit
//   RX_IN_S        in   serial line, idle high
//   Prescale       in   cycles per bit (values below 4 behave as 4)
//   parity_enable  in   1 = parity bit follows the data bits
//   parity_type    in   0 = even, 1 = odd
//   RX_OUT_P       out  last good byte, LSB first on the line
//   RX_OUT_V       out  one-cycle strobe, RX_OUT_P updated
//   parity_error   out  one-cycle pulse, parity mismatch
//   framing_error  out  one-cycle pulse, stop bit sampled low
//   current_state  out  FSM state for debug
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle, waiting for a low synchronized sample
// START  | timing the start bit, false starts return to IDLE
// DATA   | collecting DATA_WIDTH bits, LSB first
// PARITY | checking the parity bit against the collected data
// STOP   | checking the stop bit, then reporting the byte or an error
// ----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  RST,
    input  logic                  RX_CLK,
    input  logic                  RX_IN_S,
    input  logic [5:0]            Prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] RX_OUT_P,
    output logic                  RX_OUT_V,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic [2:0]            current_state
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_n;

    logic rx_meta, rxs;

    logic [5:0]            edge_cnt, edge_cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_reg_n;
    logic                  perr, perr_n;

    logic [5:0] p_cfg, p_cfg_n;
    logic       pen_cfg, pen_cfg_n;
    logic       ptype_cfg, ptype_cfg_n;

    logic samp_a, samp_b, samp_c;
    logic samp_a_n, samp_b_n, samp_c_n;

    logic [DATA_WIDTH-1:0] out_p_n;
    logic                  out_v_n;
    logic                  perr_pulse_n;
    logic                  ferr_pulse_n;

    logic [5:0] p_clamped;
    logic [5:0] samp_mid;
    logic [5:0] samp_lo;
    logic [5:0] samp_hi;
    logic [5:0] bit_last_edge;
    logic       bit_end;
    logic       third_sample;
    logic       majority;

    // ------------------------------------------------------------------------
    // Line synchronizer, resets to the idle level so reset never looks like a
    // start bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX_IN_S;
            rxs     <= rx_meta;
        end
    end

    assign p_clamped     = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign samp_mid      = p_cfg >> 1;
    assign samp_lo       = samp_mid - 6'd1;
    assign samp_hi       = samp_mid + 6'd1;
    assign bit_last_edge = p_cfg - 6'd1;
    assign bit_end       = (edge_cnt == bit_last_edge);

    // With P=4 the last sample point coincides with the bit end, so the third
    // vote has to come straight from the line rather than from its register.
    assign third_sample = (edge_cnt == samp_hi) ? rxs : samp_c;
    assign majority     = (samp_a & samp_b) | (samp_a & third_sample)
                        | (samp_b & third_sample);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            perr          <= 1'b0;
            p_cfg         <= 6'd4;
            pen_cfg       <= 1'b0;
            ptype_cfg     <= 1'b0;
            samp_a        <= 1'b1;
            samp_b        <= 1'b1;
            samp_c        <= 1'b1;
            RX_OUT_P      <= '0;
            RX_OUT_V      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            edge_cnt      <= edge_cnt_n;
            bit_cnt       <= bit_cnt_n;
            shift_reg     <= shift_reg_n;
            perr          <= perr_n;
            p_cfg         <= p_cfg_n;
            pen_cfg       <= pen_cfg_n;
            ptype_cfg     <= ptype_cfg_n;
            samp_a        <= samp_a_n;
            samp_b        <= samp_b_n;
            samp_c        <= samp_c_n;
            RX_OUT_P      <= out_p_n;
            RX_OUT_V      <= out_v_n;
            parity_error  <= perr_pulse_n;
            framing_error <= ferr_pulse_n;
        end
    end

    assign current_state = state;

    // ------------------------------------------------------------------------
    // Mid-bit sample capture
    // ------------------------------------------------------------------------
    always_comb begin
        samp_a_n = samp_a;
        samp_b_n = samp_b;
        samp_c_n = samp_c;
        if (state != IDLE) begin
            if (edge_cnt == samp_lo)  samp_a_n = rxs;
            if (edge_cnt == samp_mid) samp_b_n = rxs;
            if (edge_cnt == samp_hi)  samp_c_n = rxs;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        edge_cnt_n   = edge_cnt;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        perr_n       = perr;
        p_cfg_n      = p_cfg;
        pen_cfg_n    = pen_cfg;
        ptype_cfg_n  = ptype_cfg;
        out_p_n      = RX_OUT_P;
        out_v_n      = 1'b0;
        perr_pulse_n = 1'b0;
        ferr_pulse_n = 1'b0;

        if (state != IDLE) begin
            edge_cnt_n = bit_end ? 6'd0 : (edge_cnt + 6'd1);
        end

        case (state)
            IDLE: begin
                edge_cnt_n = '0;
                bit_cnt_n  = '0;
                if (!rxs) begin
                    // The detect cycle itself is edge 0 of the start bit.
                    state_n     = START;
                    edge_cnt_n  = 6'd1;
                    p_cfg_n     = p_clamped;
                    pen_cfg_n   = parity_enable;
                    ptype_cfg_n = parity_type;
                end
            end

            START: begin
                if (bit_end) begin
                    if (majority) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_reg_n[bit_cnt] = majority;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = pen_cfg ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    if (majority != ((^shift_reg) ^ ptype_cfg)) begin
                        perr_n       = 1'b1;
                        perr_pulse_n = 1'b1;
                    end
                    state_n = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (!majority) begin
                        ferr_pulse_n = 1'b1;
                    end else if (!perr) begin
                        out_p_n = shift_reg;
                        out_v_n = 1'b1;
                    end
                    perr_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n    = IDLE;
                edge_cnt_n = '0;
                bit_cnt_n  = '0;
                perr_n     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Drives whole UART frames onto RX_IN_S and compares what the receiver
// reports against frame-level expectations: a byte is reported only when its
// parity (if any) and stop bit are right, and RX_OUT_P always holds the most
// recent good byte.
// ----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    logic       RST;
    logic       RX_CLK;
    logic       RX_IN_S;
    logic [5:0] Prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] RX_OUT_P;
    logic       RX_OUT_V;
    logic       parity_error;
    logic       framing_error;
    logic [2:0] current_state;

    int checks = 0;
    int errors = 0;

    int       cyc = 0;
    int       launch_cyc;
    int       pe_cnt = 0;
    int       fe_cnt = 0;
    logic [7:0] v_data[$];
    int         v_time[$];

    uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
        .RST           (RST),
        .RX_CLK        (RX_CLK),
        .RX_IN_S       (RX_IN_S),
        .Prescale      (Prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .RX_OUT_P      (RX_OUT_P),
        .RX_OUT_V      (RX_OUT_V),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .current_state (current_state)
    );

    initial RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    always @(posedge RX_CLK) cyc <= cyc + 1;

    // Observed events, sampled mid-cycle. v_time is the clock edge at which a
    // synchronous consumer on RX_CLK would first capture the strobe.
    always @(negedge RX_CLK) begin
        if (RST) begin
            if (RX_OUT_V) begin
                v_data.push_back(RX_OUT_P);
                v_time.push_back(cyc + 1);
            end
            if (parity_error)  pe_cnt <= pe_cnt + 1;
            if (framing_error) fe_cnt <= fe_cnt + 1;
        end
    end

    // Every drive happens just after a rising edge and holds for p cycles.
    task automatic drive_bit(input logic b, input int p);
        RX_IN_S = b;
        repeat (p) @(posedge RX_CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit,
                              input logic stopb, input int p);
        launch_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stopb, p);
    endtask

    task automatic clear_log();
        v_data.delete();
        v_time.delete();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RX_IN_S = 1'b1;
        Prescale = 6'd8;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        checks++;
        if (RX_OUT_P !== 8'h00 || RX_OUT_V !== 1'b0 || parity_error !== 1'b0 ||
            framing_error !== 1'b0 || current_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got P=%h V=%b pe=%b fe=%b st=%0d, want all 0",
                     RX_OUT_P, RX_OUT_V, parity_error, framing_error, current_state);
        end
        RST = 1'b1;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_basic();
        int pe0, fe0;
        clear_log();
        pe0 = pe_cnt; fe0 = fe_cnt;
        Prescale = 6'd8; parity_enable = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        drive_bit(1'b1, 10);
        checks++;
        if (v_data.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d strobes, want 1", v_data.size());
        end else begin
            checks++;
            if (v_data[0] !== 8'hA5) begin
                errors++;
                $display("FAIL basic_data: got %h want a5", v_data[0]);
            end
            checks++;
            if (v_time[0] - launch_cyc != 83) begin
                errors++;
                $display("FAIL basic_latency: got %0d want 83", v_time[0] - launch_cyc);
            end
        end
        checks++;
        if (pe_cnt != pe0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL basic_errors: got pe=%0d fe=%0d want 0 0", pe_cnt - pe0, fe_cnt - fe0);
        end
    endtask

    task automatic test_parity();
        int pe0;
        clear_log();
        pe0 = pe_cnt;
        Prescale = 6'd16; parity_enable = 1'b1; parity_type = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        drive_bit(1'b1, 8);
        checks++;
        if (v_data.size() != 1 || RX_OUT_P !== 8'h3C || pe_cnt != pe0) begin
            errors++;
            $display("FAIL parity_even: got n=%0d P=%h pe=%0d, want 1 3c 0",
                     v_data.size(), RX_OUT_P, pe_cnt - pe0);
        end
        clear_log();
        parity_type = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        drive_bit(1'b1, 8);
        checks++;
        if (v_data.size() != 0 || RX_OUT_P !== 8'h3C || pe_cnt != pe0 + 1) begin
            errors++;
            $display("FAIL parity_odd: got n=%0d P=%h pe=%0d, want 0 3c 1",
                     v_data.size(), RX_OUT_P, pe_cnt - pe0);
        end
        parity_enable = 1'b0; parity_type = 1'b0;
    endtask

    task automatic test_framing();
        int  fe0;
        bit  seen;
        clear_log();
        fe0 = fe_cnt;
        seen = 1'b0;
        Prescale = 6'd8;
        launch_cyc = cyc;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) drive_bit(logic'((8'h5A >> i) & 8'h01), 8);
        RX_IN_S = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge RX_CLK);
            if (framing_error) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL framing_pulse: got none within 40 cycles, want one");
        end else begin
            checks++;
            if (current_state !== 3'd0) begin
                errors++;
                $display("FAIL framing_idle: got state %0d want 0", current_state);
            end
            @(negedge RX_CLK);
            checks++;
            if (current_state !== 3'd1) begin
                errors++;
                $display("FAIL framing_restart: got state %0d want 1", current_state);
            end
        end
        @(posedge RX_CLK); #1;
        drive_bit(1'b1, 30);
        checks++;
        if (v_data.size() != 0 || fe_cnt != fe0 + 1 || current_state !== 3'd0) begin
            errors++;
            $display("FAIL framing_after: got n=%0d fe=%0d st=%0d want 0 1 0",
                     v_data.size(), fe_cnt - fe0, current_state);
        end
    endtask

    task automatic test_false_start();
        int  pe0, fe0;
        bit  saw_start;
        clear_log();
        pe0 = pe_cnt; fe0 = fe_cnt;
        saw_start = 1'b0;
        Prescale = 6'd16;
        drive_bit(1'b0, 3);
        RX_IN_S = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge RX_CLK);
            if (current_state == 3'd1) saw_start = 1'b1;
        end
        #1;
        checks++;
        if (!saw_start || current_state !== 3'd0) begin
            errors++;
            $display("FAIL false_start_fsm: got saw_start=%b st=%0d want 1 0",
                     saw_start, current_state);
        end
        checks++;
        if (v_data.size() != 0 || pe_cnt != pe0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL false_start_quiet: got n=%0d pe=%0d fe=%0d want 0 0 0",
                     v_data.size(), pe_cnt - pe0, fe_cnt - fe0);
        end
        @(posedge RX_CLK); #1;
    endtask

    task automatic test_back_to_back();
        clear_log();
        Prescale = 6'd8; parity_enable = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8);
        drive_bit(1'b1, 10);
        checks++;
        if (v_data.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", v_data.size());
        end else begin
            checks++;
            if (v_data[0] !== 8'h01 || v_data[1] !== 8'hFF) begin
                errors++;
                $display("FAIL b2b_data: got %h %h want 01 ff", v_data[0], v_data[1]);
            end
            checks++;
            if (v_time[1] - v_time[0] != 80) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want 80", v_time[1] - v_time[0]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int pe0, fe0;
        Prescale = 6'd16; parity_enable = 1'b0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(logic'((8'h5A >> i) & 8'h01), 16);
        drive_bit(1'b1, 5);
        RST = 1'b0;
        #1;
        checks++;
        if (RX_OUT_P !== 8'h00 || RX_OUT_V !== 1'b0 || parity_error !== 1'b0 ||
            framing_error !== 1'b0 || current_state !== 3'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got P=%h V=%b pe=%b fe=%b st=%0d want all 0",
                     RX_OUT_P, RX_OUT_V, parity_error, framing_error, current_state);
        end
        RX_IN_S = 1'b1;
        repeat (5) @(posedge RX_CLK);
        #1;
        RST = 1'b1;
        drive_bit(1'b1, 20);
        clear_log();
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16);
        drive_bit(1'b1, 10);
        checks++;
        if (v_data.size() != 1 || pe_cnt != pe0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL midreset_count: got n=%0d pe=%0d fe=%0d want 1 0 0",
                     v_data.size(), pe_cnt - pe0, fe_cnt - fe0);
        end else begin
            checks++;
            if (v_data[0] !== 8'h81) begin
                errors++;
                $display("FAIL midreset_data: got %h want 81", v_data[0]);
            end
        end
    endtask

    // Random frames with random bit rate (including clamped values), parity
    // settings, corrupted parity bits and bad stop bits.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] last_good;
        int         exp_pe, exp_fe, pe0, fe0;
        clear_log();
        pe0 = pe_cnt; fe0 = fe_cnt;
        exp_pe = 0; exp_fe = 0;
        last_good = RX_OUT_P;
        for (int f = 0; f < 30; f++) begin
            int         p_raw, p_eff, gap;
            logic [7:0] data;
            logic       pen, ptype, pbit, stopb, bad_par;
            p_raw = $urandom_range(2, 20);
            p_eff = (p_raw < 4) ? 4 : p_raw;
            data  = 8'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            pbit  = (^data) ^ ptype;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stopb = ($urandom_range(0, 4) != 0);
            gap   = $urandom_range(0, 2);
            if (!stopb && gap == 0) gap = 1;
            Prescale = 6'(p_raw);
            parity_enable = pen;
            parity_type = ptype;
            bad_par = pen && (pbit != ((^data) ^ ptype));
            if (bad_par) exp_pe++;
            if (!stopb) exp_fe++;
            if (!bad_par && stopb) begin
                exp_q.push_back(data);
                last_good = data;
            end
            send_frame(data, pen, pbit, stopb, p_eff);
            if (gap > 0) drive_bit(1'b1, gap * p_eff);
        end
        drive_bit(1'b1, 30);
        checks++;
        if (v_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d want %0d", v_data.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (v_data[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_data[%0d]: got %h want %h", i, v_data[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (pe_cnt - pe0 != exp_pe || fe_cnt - fe0 != exp_fe) begin
            errors++;
            $display("FAIL random_errors: got pe=%0d fe=%0d want %0d %0d",
                     pe_cnt - pe0, fe_cnt - fe0, exp_pe, exp_fe);
        end
        checks++;
        if (RX_OUT_P !== last_good) begin
            errors++;
            $display("FAIL random_hold: got %h want %h", RX_OUT_P, last_good);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_mid_frame_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
